// File: rtl/hci_wrr_package.sv
// Shared types and helpers for the HCI weighted round-robin scheduler.
package hci_wrr_package;

    localparam int unsigned MAX_REQ = 32;
    localparam int unsigned MAX_IW  = 5;

    typedef struct packed {
        logic              found;
        logic [MAX_IW-1:0] idx;
    } rr_pick_t;

    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set bit of vec[0 +: n], scanning ptr, ptr+1, ... wrapping at n.
    function automatic rr_pick_t rr_first_one(logic [MAX_REQ-1:0] vec,
                                              int unsigned n,
                                              int unsigned ptr);
        rr_pick_t    r;
        int unsigned j;
        r = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (i < n) begin
                j = ptr + i;
                if (j >= n) j = j - n;
                if (!r.found && vec[j[MAX_IW-1:0]]) begin
                    r.found = 1'b1;
                    r.idx   = j[MAX_IW-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hci_wrr_resp_fifo.sv
// In-order index FIFO; records read winners for response routing.
module hci_wrr_resp_fifo
    import hci_wrr_package::*;
#(
    parameter int unsigned DW    = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [DW-1:0]              data_i,
    input  logic                       pop_i,
    output logic [DW-1:0]              data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PW = idx_width(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] nxt(logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clear_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= nxt(wr_q);
            if (do_pop)  rd_q <= nxt(rd_q);
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/hci_core_wrr_scheduler.sv
// Weighted round-robin arbiter for one shared HCI initiator port.
// Optional starvation guard: define HCI_WRR_STARVE_GUARD_EN.
module hci_core_wrr_scheduler
    import hci_wrr_package::*;
#(
    parameter int unsigned NB_REQ          = 4,
    parameter int unsigned WW              = 4,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned STARVE_LIMIT    = 64
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 clear_i,
    input  logic [NB_REQ*WW-1:0]                 weight_i,
    input  logic [NB_REQ-1:0]                    req_i,
    input  logic [NB_REQ-1:0]                    wen_i,
    output logic [NB_REQ-1:0]                    gnt_o,
    output logic [$clog2(NB_REQ)-1:0]            sel_o,
    output logic                                 out_req_o,
    input  logic                                 out_gnt_i,
    input  logic                                 out_r_valid_i,
    input  logic                                 out_r_ready_i,
    output logic [$clog2(NB_REQ)-1:0]            r_sel_o,
    output logic [NB_REQ-1:0]                    r_valid_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 resp_err_o
);

    localparam int unsigned IW = $clog2(NB_REQ);

    logic [WW-1:0]     credit_q [NB_REQ];
    logic [IW-1:0]     ptr_q;
    logic              load_q;
    logic [NB_REQ-1:0] eligible;
    rr_pick_t          pick, spick;
    logic              starve_win, any, hs, refill;
    logic [IW-1:0]     winner, head;
    logic              fifo_full, fifo_empty;
    logic [2*MAX_IW-1:0] unused_idx;

    always_comb begin
        eligible = '0;
        for (int k = 0; k < NB_REQ; k++)
            eligible[k] = req_i[k] & (credit_q[k] != '0);
    end

    assign pick       = rr_first_one(MAX_REQ'(eligible), NB_REQ, 32'(ptr_q));
    assign unused_idx = {pick.idx, spick.idx};

`ifdef HCI_WRR_STARVE_GUARD_EN
    localparam int unsigned SW = $clog2(STARVE_LIMIT+1);

    logic [SW-1:0]     wait_q [NB_REQ];
    logic [NB_REQ-1:0] starving;

    always_comb begin
        starving = '0;
        for (int k = 0; k < NB_REQ; k++)
            starving[k] = req_i[k] & (wait_q[k] >= SW'(STARVE_LIMIT));
    end

    assign spick      = rr_first_one(MAX_REQ'(starving), NB_REQ, 0);
    assign starve_win = spick.found;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NB_REQ; k++) wait_q[k] <= '0;
        end else if (clear_i) begin
            for (int k = 0; k < NB_REQ; k++) wait_q[k] <= '0;
        end else begin
            for (int k = 0; k < NB_REQ; k++) begin
                if (!req_i[k] || gnt_o[k])
                    wait_q[k] <= '0;
                else if (wait_q[k] != '1)
                    wait_q[k] <= wait_q[k] + 1'b1;
            end
        end
    end
`else
    logic [$clog2(STARVE_LIMIT+1)-1:0] unused_lim;
    assign unused_lim = '0;
    assign spick      = '0;
    assign starve_win = 1'b0;
`endif

    assign winner    = starve_win ? spick.idx[IW-1:0] : pick.idx[IW-1:0];
    assign any       = starve_win | pick.found;
    assign sel_o     = any ? winner : '0;
    // Grants held off while credits are being loaded or the FIFO is full.
    assign out_req_o = any & ~fifo_full & ~load_q & ~clear_i;
    assign hs        = out_req_o & out_gnt_i;
    assign refill    = (req_i != '0) & ~any & ~load_q;

    always_comb begin
        gnt_o = '0;
        if (hs) gnt_o[winner] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NB_REQ; k++) credit_q[k] <= '0;
            ptr_q  <= '0;
            load_q <= 1'b1;
        end else if (clear_i) begin
            for (int k = 0; k < NB_REQ; k++) credit_q[k] <= '0;
            ptr_q  <= '0;
            load_q <= 1'b1;
        end else begin
            load_q <= 1'b0;
            if (load_q || refill) begin
                for (int k = 0; k < NB_REQ; k++)
                    credit_q[k] <= weight_i[k*WW +: WW];
            end else if (hs && credit_q[winner] != '0) begin
                credit_q[winner] <= credit_q[winner] - 1'b1;
            end
            if (hs && !starve_win && credit_q[winner] == WW'(1))
                ptr_q <= (winner == IW'(NB_REQ-1)) ? '0 : winner + 1'b1;
        end
    end

    hci_wrr_resp_fifo #(
        .DW    (IW),
        .DEPTH (MAX_OUTSTANDING)
    ) i_resp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (hs & wen_i[winner]),
        .data_i  (winner),
        .pop_i   (out_r_valid_i & out_r_ready_i),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding_o)
    );

    assign r_sel_o    = fifo_empty ? '0 : head;
    assign resp_err_o = out_r_valid_i & fifo_empty;

    always_comb begin
        r_valid_o = '0;
        if (out_r_valid_i && !fifo_empty) r_valid_o[head] = 1'b1;
    end

endmodule

// File: tb/tb_hci_core_wrr_scheduler.sv
// Scoreboard bench for hci_core_wrr_scheduler (NB_REQ=4, default build).
module tb_hci_core_wrr_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clear_i;
    logic [15:0] weight_i;
    logic [3:0]  req_i, wen_i, gnt_o, r_valid_o;
    logic [1:0]  sel_o, r_sel_o;
    logic        out_req_o, out_gnt_i, out_r_valid_i, out_r_ready_i;
    logic [2:0]  outstanding_o;
    logic        resp_err_o;

    always #5 clk_i = ~clk_i;

    hci_core_wrr_scheduler #(
        .NB_REQ(4), .WW(4), .MAX_OUTSTANDING(4), .STARVE_LIMIT(64)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .weight_i(weight_i), .req_i(req_i), .wen_i(wen_i),
        .gnt_o(gnt_o), .sel_o(sel_o), .out_req_o(out_req_o),
        .out_gnt_i(out_gnt_i), .out_r_valid_i(out_r_valid_i),
        .out_r_ready_i(out_r_ready_i), .r_sel_o(r_sel_o),
        .r_valid_o(r_valid_o), .outstanding_o(outstanding_o),
        .resp_err_o(resp_err_o)
    );

    typedef struct packed {
        logic       rq;
        logic [1:0] sel;
        logic [3:0] gnt;
        logic [1:0] rs;
        logic [3:0] rv;
        logic [2:0] o;
        logic       er;
    } exp_t;

    exp_t  exp_q [$];
    string name_q [$];
    int    compared = 0;
    int    mismatched = 0;

    function automatic exp_t ex(bit rq, int s, bit rv, int rs, int o, bit er);
        exp_t e;
        logic [3:0] one = 4'b0001;
        e.rq  = rq;
        e.sel = 2'(s);
        e.gnt = rq ? (one << s) : 4'b0;
        e.rs  = 2'(rs);
        e.rv  = rv ? (one << rs) : 4'b0;
        e.o   = 3'(o);
        e.er  = er;
        return e;
    endfunction

    always @(negedge clk_i) begin
        exp_t  e, got;
        string n;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            n   = name_q.pop_front();
            got = {out_req_o, sel_o, gnt_o, r_sel_o, r_valid_o,
                   outstanding_o, resp_err_o};
            compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL %s: got req=%b sel=%0d gnt=%b rsel=%0d rv=%b out=%0d err=%b, expected req=%b sel=%0d gnt=%b rsel=%0d rv=%b out=%0d err=%b",
                         n, got.rq, got.sel, got.gnt, got.rs, got.rv, got.o, got.er,
                         e.rq, e.sel, e.gnt, e.rs, e.rv, e.o, e.er);
            end
        end
    end

    task automatic step(input logic rst, input logic clr,
                        input logic [3:0] rq, input logic [3:0] wn,
                        input logic rvi, input bit chk,
                        input string n, input exp_t e);
        @(posedge clk_i);
        #1;
        rst_ni        = rst;
        clear_i       = clr;
        req_i         = rq;
        wen_i         = wn;
        out_r_valid_i = rvi;
        if (chk) begin
            exp_q.push_back(e);
            name_q.push_back(n);
        end
    endtask

    task automatic clr_load(input logic [3:0] rq, input logic [3:0] wn);
        step(1, 1, rq, wn, 0, 0, "clear", ex(0, 0, 0, 0, 0, 0));
        step(1, 0, rq, wn, 0, 1, "load", ex(0, 0, 0, 0, 0, 0));
    endtask

    int t1 [7] = '{0, 1, 2, 3, -1, 0, 1};
    int t2 [13] = '{0, 0, 0, 1, 3, 3, -1, 0, 0, 0, 1, 3, 3};

    initial begin
        rst_ni = 1'b0; clear_i = 1'b0;
        weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
        req_i = '0; wen_i = '0;
        out_gnt_i = 1'b1; out_r_valid_i = 1'b0; out_r_ready_i = 1'b1;

        step(0, 0, 4'h0, 4'h0, 0, 1, "reset", ex(0, 0, 0, 0, 0, 0));
        step(0, 0, 4'hF, 4'h0, 0, 1, "reset_req", ex(0, 0, 0, 0, 0, 0));
        step(1, 0, 4'hF, 4'h0, 0, 1, "load", ex(0, 0, 0, 0, 0, 0));

        foreach (t1[i])
            step(1, 0, 4'hF, 4'h0, 0, 1, "rr_equal",
                 ex(t1[i] >= 0, (t1[i] >= 0) ? t1[i] : 0, 0, 0, 0, 0));

        weight_i = {4'd2, 4'd0, 4'd1, 4'd3};
        clr_load(4'hF, 4'h0);
        foreach (t2[i])
            step(1, 0, 4'hF, 4'h0, 0, 1, "wrr_weighted",
                 ex(t2[i] >= 0, (t2[i] >= 0) ? t2[i] : 0, 0, 0, 0, 0));

        weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
        clr_load(4'hF, 4'hF);
        step(1, 0, 4'hF, 4'hF, 0, 1, "rd_g0", ex(1, 0, 0, 0, 0, 0));
        step(1, 0, 4'hF, 4'hF, 0, 1, "rd_g1", ex(1, 1, 0, 0, 1, 0));
        step(1, 0, 4'hF, 4'hF, 0, 1, "rd_g2", ex(1, 2, 0, 0, 2, 0));
        step(1, 0, 4'hF, 4'hF, 0, 1, "rd_g3", ex(1, 3, 0, 0, 3, 0));
        step(1, 0, 4'hF, 4'hF, 0, 1, "full_refill", ex(0, 0, 0, 0, 4, 0));
        step(1, 0, 4'hF, 4'hF, 0, 1, "full_block", ex(0, 0, 0, 0, 4, 0));
        step(1, 0, 4'hF, 4'hF, 1, 1, "pop_on_full", ex(0, 0, 1, 0, 4, 0));
        step(1, 0, 4'h0, 4'hF, 0, 1, "after_pop", ex(0, 0, 0, 1, 3, 0));
        step(1, 0, 4'h0, 4'hF, 1, 1, "pop_r1", ex(0, 0, 1, 1, 3, 0));
        step(1, 0, 4'h1, 4'hF, 1, 1, "push_pop", ex(1, 0, 1, 2, 2, 0));
        step(1, 0, 4'h0, 4'hF, 1, 1, "pop_r3", ex(0, 0, 1, 3, 2, 0));
        step(1, 0, 4'h0, 4'hF, 1, 1, "pop_r0", ex(0, 0, 1, 0, 1, 0));
        step(1, 0, 4'h0, 4'hF, 1, 1, "resp_err", ex(0, 0, 0, 0, 0, 1));
        step(1, 0, 4'h0, 4'hF, 0, 1, "err_clear", ex(0, 0, 0, 0, 0, 0));

        clr_load(4'hF, 4'hF);
        step(1, 0, 4'hF, 4'hF, 0, 1, "burst_g0", ex(1, 0, 0, 0, 0, 0));
        step(1, 0, 4'hF, 4'hF, 0, 1, "burst_g1", ex(1, 1, 0, 0, 1, 0));
        step(0, 0, 4'hF, 4'hF, 0, 1, "async_rst", ex(0, 0, 0, 0, 0, 0));
        step(0, 0, 4'hF, 4'hF, 0, 1, "rst_hold", ex(0, 0, 0, 0, 0, 0));
        step(1, 0, 4'hF, 4'hF, 0, 1, "rst_load", ex(0, 0, 0, 0, 0, 0));
        step(1, 0, 4'hF, 4'hF, 0, 1, "rst_g0", ex(1, 0, 0, 0, 0, 0));
        step(1, 0, 4'h0, 4'h0, 0, 0, "idle", ex(0, 0, 0, 0, 0, 0));

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk_i);
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expected entries left, required 0",
                     exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
